// File: rtl/bcd_seq_pkg.sv
// Shared types and constants for the sequential BCD adder.
package bcd_seq_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BCD_MAX  = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_CORR = 4'd6;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

endpackage

// File: rtl/bcd_seq_adder_ctrl_if.sv
// Request/result bundle between the front end and the sequential BCD adder.
interface bcd_seq_adder_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  i_start;
    logic [4*DIGITS-1:0]   i_a_bcd;
    logic [4*DIGITS-1:0]   i_b_bcd;
    logic                  i_cin;
    logic                  o_busy;
    logic                  o_done;
    logic [4*DIGITS-1:0]   o_sum;
    logic                  o_cout;
    logic                  o_error;

    modport master (
        output i_start, i_a_bcd, i_b_bcd, i_cin,
        input  o_busy, o_done, o_sum, o_cout, o_error
    );

    modport slave (
        input  i_start, i_a_bcd, i_b_bcd, i_cin,
        output o_busy, o_done, o_sum, o_cout, o_error
    );
endinterface

// File: rtl/bcd_digit_slice.sv
// Combinational single-digit BCD add with decimal carry and invalid-digit flag.
module bcd_digit_slice
    import bcd_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_x,
    input  logic [DIGIT_W-1:0] i_y,
    input  logic               i_c,
    output logic [DIGIT_W-1:0] o_digit,
    output logic               o_carry,
    output logic               o_invalid
);
    logic [DIGIT_W:0] w_t;

    // NOTE: every output gets a default before the if, so no latch is inferred.
    always_comb begin
        w_t       = {1'b0, i_x} + {1'b0, i_y} + {{DIGIT_W{1'b0}}, i_c};
        o_digit   = w_t[DIGIT_W-1:0];
        o_carry   = 1'b0;
        if (w_t > {1'b0, BCD_MAX}) begin
            o_digit = w_t[DIGIT_W-1:0] + BCD_CORR;
            o_carry = 1'b1;
        end
        o_invalid = (i_x > BCD_MAX) || (i_y > BCD_MAX);
    end
endmodule

// File: rtl/bcd_seq_adder_ctrl.sv
// Multi-digit BCD adder sharing one digit slice, LSD first, one digit per clock.
// Optional macro BCD_SEQ_ERR_ABORT_EN: finish early on the first invalid digit.
module bcd_seq_adder_ctrl
    import bcd_seq_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    bcd_seq_adder_ctrl_if.slave bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t                          r_state;
    logic [IDX_W-1:0]                r_idx;
    logic [DIGITS-1:0][DIGIT_W-1:0]  r_a;
    logic [DIGITS-1:0][DIGIT_W-1:0]  r_b;
    logic [DIGITS-1:0][DIGIT_W-1:0]  r_sh;
    logic [DIGITS-1:0][DIGIT_W-1:0]  r_sum;
    logic                            r_carry;
    logic                            r_err;
    logic                            r_busy;
    logic                            r_done;
    logic                            r_cout;
    logic                            r_error;

    logic [DIGIT_W-1:0]              w_digit;
    logic                            w_carry;
    logic                            w_invalid;
    logic                            w_exit;
    logic [DIGITS-1:0][DIGIT_W-1:0]  w_fin_sum;
    logic                            w_fin_cout;

    bcd_digit_slice u_slice (
        .i_x       (r_a[r_idx]),
        .i_y       (r_b[r_idx]),
        .i_c       (r_carry),
        .o_digit   (w_digit),
        .o_carry   (w_carry),
        .o_invalid (w_invalid)
    );

`ifdef BCD_SEQ_ERR_ABORT_EN
    assign w_exit = (r_idx == LAST_IDX) || w_invalid;
`else
    assign w_exit = (r_idx == LAST_IDX);
`endif

    // An invalid operand suppresses the arithmetic result entirely.
    assign w_fin_sum  = r_err ? '0 : r_sh;
    assign w_fin_cout = r_err ? 1'b0 : r_carry;

    // During DONE the fresh result is shown directly; afterwards the held copy.
    assign bus.o_busy  = r_busy;
    assign bus.o_done  = r_done;
    assign bus.o_sum   = r_done ? w_fin_sum  : r_sum;
    assign bus.o_cout  = r_done ? w_fin_cout : r_cout;
    assign bus.o_error = r_done ? r_err      : r_error;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of its peers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sh    <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cout  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.i_start) begin
                        r_a     <= bus.i_a_bcd;
                        r_b     <= bus.i_b_bcd;
                        r_carry <= bus.i_cin;
                        r_idx   <= '0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ADD;
                    end
                end
                ADD: begin
                    r_sh    <= {w_digit, r_sh[DIGITS-1:1]};
                    r_carry <= w_carry;
                    r_err   <= r_err | w_invalid;
                    if (w_exit) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    r_sum   <= w_fin_sum;
                    r_cout  <= w_fin_cout;
                    r_error <= r_err;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_seq_adder_ctrl.sv
// Self-checking bench for bcd_seq_adder_ctrl: vector table, scoreboard queue,
// latency/busy checks and reset/restart corner sequences.
module tb_bcd_seq_adder_ctrl;
    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
    } vec_t;

    logic clk;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t sb[$];
    vec_t tbl[10];

    bcd_seq_adder_ctrl_if #(.DIGITS(DIGITS)) bus ();

    bcd_seq_adder_ctrl #(.DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                input logic [W-1:0] sum, input logic cout, input logic err);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.sum = sum; v.cout = cout; v.err = err;
        return v;
    endfunction

    // Reference: decimal integer arithmetic, not digit-serial.
    function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        vec_t        v;
        int unsigned da, db, s, p, xa, xb;
        bit          bad;
        da = 0; db = 0; p = 1; bad = 0;
        for (int k = 0; k < DIGITS; k++) begin
            xa = 32'(a[4*k +: 4]);
            xb = 32'(b[4*k +: 4]);
            if (xa > 9 || xb > 9) bad = 1;
            da += xa * p;
            db += xb * p;
            p  *= 10;
        end
        v.a = a; v.b = b; v.cin = cin; v.sum = '0;
        if (bad) begin
            v.cout = 1'b0; v.err = 1'b1;
        end else begin
            s      = da + db + 32'(cin);
            v.cout = (s >= p);
            s      = s % p;
            for (int k = 0; k < DIGITS; k++) begin
                v.sum[4*k +: 4] = 4'(s % 10);
                s = s / 10;
            end
            v.err = 1'b0;
        end
        return v;
    endfunction

    function automatic int exp_latency(input logic [W-1:0] a, input logic [W-1:0] b);
        int lat;
        lat = DIGITS + 1;
`ifdef BCD_SEQ_ERR_ABORT_EN
        for (int k = DIGITS - 1; k >= 0; k--)
            if (a[4*k +: 4] > 4'd9 || b[4*k +: 4] > 4'd9) lat = k + 2;
`endif
        return lat;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // restart_k / reset_k: cycle after the start edge at which to pulse start
    // again or assert reset (0 = never).
    task automatic run_op(input vec_t v, input int restart_k, input int reset_k);
        int   lat, busy_cnt, exp_l, done_cnt;
        bit   seen;
        vec_t e;
        exp_l = exp_latency(v.a, v.b);
        @(negedge clk);
        bus.i_a_bcd = v.a;
        bus.i_b_bcd = v.b;
        bus.i_cin   = v.cin;
        bus.i_start = 1'b1;
        sb.push_back(v);
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_a_bcd = W'($urandom);
        bus.i_b_bcd = W'($urandom);
        bus.i_cin   = ~bus.i_cin;
        seen = 0; busy_cnt = 0; lat = 0;
        for (int k = 1; k <= DIGITS + 4 && !seen; k++) begin
            if (k == reset_k) begin
                rst = 1'b1;
                #1;
                check("rst_busy",  32'(bus.o_busy),  32'd0);
                check("rst_done",  32'(bus.o_done),  32'd0);
                check("rst_sum",   32'(bus.o_sum),   32'd0);
                check("rst_cout",  32'(bus.o_cout),  32'd0);
                check("rst_error", 32'(bus.o_error), 32'd0);
                sb.delete();
                @(negedge clk);
                rst = 1'b0;
                done_cnt = 0;
                repeat (DIGITS + 4) begin
                    @(negedge clk);
                    if (bus.o_done) done_cnt++;
                end
                check("no_done_after_rst", 32'(done_cnt), 32'd0);
                return;
            end
            bus.i_start = (k == restart_k);
            if (bus.o_done) begin
                seen = 1;
                lat  = k;
            end else begin
                if (bus.o_busy) busy_cnt++;
                @(negedge clk);
            end
        end
        bus.i_start = 1'b0;
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        check("latency",    32'(lat),         32'(exp_l));
        check("busy_count", 32'(busy_cnt),    32'(exp_l - 1));
        check("busy_in_done", 32'(bus.o_busy), 32'd0);
        if (sb.size() == 0) begin
            check("sb_empty_on_done", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("sum",   32'(bus.o_sum),   32'(e.sum));
            check("cout",  32'(bus.o_cout),  32'(e.cout));
            check("error", 32'(bus.o_error), 32'(e.err));
        end
        @(negedge clk);
        check("done_pulse_width", 32'(bus.o_done), 32'd0);
        check("idle_after_done",  32'(bus.o_busy), 32'd0);
        check("sum_hold",         32'(bus.o_sum),  32'(e.sum));
    endtask

    initial begin
        vec_t v;
        rst         = 1'b1;
        bus.i_start = 1'b0;
        bus.i_a_bcd = '0;
        bus.i_b_bcd = '0;
        bus.i_cin   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy",  32'(bus.o_busy),  32'd0);
        check("reset_done",  32'(bus.o_done),  32'd0);
        check("reset_sum",   32'(bus.o_sum),   32'd0);
        check("reset_cout",  32'(bus.o_cout),  32'd0);
        check("reset_error", 32'(bus.o_error), 32'd0);
        rst = 1'b0;

        tbl[0] = mk(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
        tbl[1] = mk(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        tbl[2] = mk(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);
        tbl[3] = mk(16'h12A4, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
        tbl[4] = mk(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
        tbl[5] = mk(16'h5050, 16'h4950, 1'b0, 16'h0000, 1'b1, 1'b0);
        tbl[6] = mk(16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0);
        tbl[7] = mk(16'hA000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
        tbl[8] = mk(16'h000A, 16'h0009, 1'b1, 16'h0000, 1'b0, 1'b1);
        tbl[9] = mk(16'h4321, 16'h1111, 1'b1, 16'h5433, 1'b0, 1'b0);

        foreach (tbl[i]) run_op(tbl[i], 0, 0);

        repeat (6) begin
            v = model(rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)));
            run_op(v, 0, 0);
        end

        // Second start mid-operation must be ignored.
        run_op(tbl[0], 2, 0);
        // Reset mid-operation discards the result; a fresh start then works.
        run_op(tbl[0], 0, 3);
        run_op(tbl[1], 0, 0);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
